// File: rtl/genius_pkg.sv
// Shared types and helpers for the Genius button path.
// Holds the button count, conditioner FSM states and the one-hot test.
package genius_pkg;

  localparam int NUM_BOTOES = 7;

  typedef enum logic [1:0] {
    ESPERA_SOLTAR = 2'b00,
    LIVRE         = 2'b01,
    PRESSIONADO   = 2'b10,
    MULTIPLO      = 2'b11
  } estado_t;

  function automatic logic eh_one_hot(
    input logic [NUM_BOTOES-1:0] v
  );
    return $countones(v) == 1;
  endfunction

endpackage

// File: rtl/debounce_vetor.sv
// Two-flop synchroniser plus whole-vector debounce.
// The vector is accepted only after staying unchanged for DEBOUNCE_CYCLES.
module debounce_vetor #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LARGURA         = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] entrada,
  output logic [LARGURA-1:0] estavel,
  output logic               valido
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [LARGURA-1:0] sinc1;
  logic [LARGURA-1:0] sinc;
  logic [LARGURA-1:0] candidato;
  logic [CW-1:0]      cnt;

  // valido marks that estavel has been confirmed at least once since reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sinc1     <= '0;
      sinc      <= '0;
      candidato <= '0;
      cnt       <= '0;
      estavel   <= '0;
      valido    <= 1'b0;
    end else begin
      sinc1 <= entrada;
      sinc  <= sinc1;
      if (sinc != candidato) begin
        candidato <= sinc;
        cnt       <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end else begin
        estavel <= candidato;
        valido  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/condicionador_botoes.sv
// Button conditioner: debounce, single-press validation, play strobe.
// Multi-button vectors are flagged and never produce a play.
module condicionador_botoes
  import genius_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_BOTOES-1:0] botoes_raw,
  output logic [NUM_BOTOES-1:0] botoes,
  output logic                  jogada,
  output logic                  multiplas,
  output logic [1:0]            db_estado
);

  logic [NUM_BOTOES-1:0] estavel;
  logic                  valido;

  debounce_vetor #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LARGURA        (NUM_BOTOES)
  ) u_debounce (
    .clock  (clock),
    .reset  (reset),
    .entrada(botoes_raw),
    .estavel(estavel),
    .valido (valido)
  );

  estado_t               estado;
  estado_t               prox;
  logic [NUM_BOTOES-1:0] botoes_prox;
  logic                  jogada_prox;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= ESPERA_SOLTAR;
      botoes <= '0;
      jogada <= 1'b0;
    end else begin
      estado <= prox;
      botoes <= botoes_prox;
      jogada <= jogada_prox;
    end
  end

  // Leaving ESPERA_SOLTAR needs a confirmed release, not the reset zero
  always_comb begin
    prox        = estado;
    botoes_prox = botoes;
    jogada_prox = 1'b0;
    unique case (estado)
      ESPERA_SOLTAR: begin
        if (valido && estavel == '0)
          prox = LIVRE;
      end
      LIVRE: begin
        if (eh_one_hot(estavel)) begin
          botoes_prox = estavel;
          jogada_prox = 1'b1;
          prox        = PRESSIONADO;
        end else if (estavel != '0) begin
          prox = MULTIPLO;
        end
      end
      PRESSIONADO: begin
        if (estavel == '0)
          prox = LIVRE;
        else if (estavel != botoes)
          prox = MULTIPLO;
      end
      MULTIPLO: begin
        if (estavel == '0)
          prox = LIVRE;
      end
      default: prox = ESPERA_SOLTAR;
    endcase
  end

  assign multiplas = (estado == MULTIPLO);
  assign db_estado = estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed and random checks of condicionador_botoes (DEBOUNCE_CYCLES=4)
// against a run-length reference model of the button rules.
module tb_condicionador_botoes;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] raw = '0;
  logic [6:0] botoes;
  logic       jogada;
  logic       multiplas;
  logic [1:0] db_estado;

  condicionador_botoes #(.DEBOUNCE_CYCLES(D)) dut (
    .clock     (clk),
    .reset     (rst),
    .botoes_raw(raw),
    .botoes    (botoes),
    .jogada    (jogada),
    .multiplas (multiplas),
    .db_estado (db_estado)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int pulses = 0;

  // Reference model: mode 0 wait-release, 1 free, 2 pressed, 3 multiple
  logic [6:0] m_s1, m_s2, m_last, m_est, m_bot;
  logic       m_val, m_jog;
  int         m_run, m_mode;

  task automatic model_step();
    logic [6:0] s;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_last = '0; m_est = '0;
      m_bot = '0; m_val = 1'b0; m_jog = 1'b0;
      m_run = 1; m_mode = 0;
    end else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      m_jog = 1'b0;
      case (m_mode)
        0: if (m_val && m_est == 0) m_mode = 1;
        1: begin
          if ($countones(m_est) == 1) begin
            m_bot = m_est; m_jog = 1'b1; m_mode = 2;
          end else if (m_est != 0) m_mode = 3;
        end
        2: begin
          if (m_est == 0) m_mode = 1;
          else if (m_est != m_bot) m_mode = 3;
        end
        default: if (m_est == 0) m_mode = 1;
      endcase
      if (s == m_last) m_run++;
      else begin m_last = s; m_run = 1; end
      if (m_run >= D + 1) begin m_est = m_last; m_val = 1'b1; end
    end
  endtask

  task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (jogada === 1'b1) pulses++;
    chk("model_botoes", botoes, m_bot);
    chk("model_jogada", {6'b0, jogada}, {6'b0, m_jog});
    chk("model_multiplas", {6'b0, multiplas}, {6'b0, m_mode == 3});
    chk("model_estado", {5'b0, db_estado}, 7'(m_mode));
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset state
    rst = 1'b1; raw = '0;
    ticks(2);
    chk("rst_botoes", botoes, 7'b0);
    chk("rst_jogada", {6'b0, jogada}, 7'b0);
    chk("rst_multiplas", {6'b0, multiplas}, 7'b0);
    chk("rst_estado", {5'b0, db_estado}, 7'd0);
    rst = 1'b0;
    ticks(10);
    chk("idle_estado", {5'b0, db_estado}, 7'd1);

    // 1: clean single press
    pulses = 0; raw = 7'b0000100;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 7) chk("t1_no_early", {6'b0, jogada}, 7'b0);
      if (i == 8) chk("t1_jogada", {6'b0, jogada}, 7'b1);
      if (i == 9) chk("t1_one_cycle", {6'b0, jogada}, 7'b0);
    end
    chk("t1_pulses", 7'(pulses), 7'd1);
    chk("t1_botoes", botoes, 7'b0000100);
    chk("t1_multiplas", {6'b0, multiplas}, 7'b0);
    raw = '0; ticks(12);

    // 2: chatter then stable
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      raw = {6'b0, ~i[1]};
      tick();
    end
    chk("t2_chatter", 7'(pulses), 7'd0);
    raw = 7'b0000001;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 8) chk("t2_jogada", {6'b0, jogada}, 7'b1);
    end
    chk("t2_pulses", 7'(pulses), 7'd1);
    raw = '0; ticks(12);

    // 3: simultaneous press
    pulses = 0; raw = 7'b0010010;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 7) chk("t3_mult_early", {6'b0, multiplas}, 7'b0);
      if (i == 8) chk("t3_multiplas", {6'b0, multiplas}, 7'b1);
    end
    chk("t3_pulses", 7'(pulses), 7'd0);
    raw = '0; ticks(12);
    chk("t3_rel_mult", {6'b0, multiplas}, 7'b0);
    chk("t3_rel_estado", {5'b0, db_estado}, 7'd1);

    // 4: second button added, then new press
    pulses = 0; raw = 7'b0000001; ticks(12);
    chk("t4_first", 7'(pulses), 7'd1);
    raw = 7'b1000001; ticks(12);
    chk("t4_no_second", 7'(pulses), 7'd1);
    chk("t4_multiplas", {6'b0, multiplas}, 7'b1);
    chk("t4_botoes_kept", botoes, 7'b0000001);
    raw = '0; ticks(12);
    raw = 7'b1000000; ticks(12);
    chk("t4_new_pulse", 7'(pulses), 7'd2);
    chk("t4_new_botoes", botoes, 7'b1000000);
    raw = '0; ticks(12);

    // 5: button held through reset
    pulses = 0; raw = 7'b0001000; rst = 1'b1;
    ticks(2);
    rst = 1'b0; ticks(20);
    chk("t5_held", 7'(pulses), 7'd0);
    chk("t5_estado", {5'b0, db_estado}, 7'd0);
    raw = '0; ticks(12);
    chk("t5_rel_estado", {5'b0, db_estado}, 7'd1);
    raw = 7'b0001000; ticks(12);
    chk("t5_repress", 7'(pulses), 7'd1);
    raw = '0; ticks(12);

    // 6: reset on the strobe cycle
    raw = 7'b0000010; ticks(8);
    chk("t6_jogada", {6'b0, jogada}, 7'b1);
    rst = 1'b1; tick();
    chk("t6_botoes", botoes, 7'b0);
    chk("t6_jogada0", {6'b0, jogada}, 7'b0);
    chk("t6_multiplas", {6'b0, multiplas}, 7'b0);
    chk("t6_estado", {5'b0, db_estado}, 7'd0);
    rst = 1'b0; raw = '0; ticks(12);

    // random segments against the model
    for (int seg = 0; seg < 80; seg++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 2)      raw = '0;
      else if (k < 8) raw = 7'(1 << $urandom_range(0, 6));
      else if (k == 8)
        raw = 7'(1 << $urandom_range(0, 6)) | 7'(1 << $urandom_range(0, 6));
      else            raw = 7'($urandom_range(0, 127));
      rst = ($urandom_range(0, 29) == 0);
      tick();
      rst = 1'b0;
      ticks($urandom_range(0, 10));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
